// File: rtl/pic_ctrl_pkg.sv
// Shared types and opcode tables for the PIC-style four-phase sequencer.
// Optional single-step support is enabled with the PIC_CTRL_STEP_EN macro (see pic_ctrl_seq).
package pic_ctrl_pkg;

    typedef enum logic [1:0] {
        PH_FETCH     = 2'd0,
        PH_DECODE    = 2'd1,
        PH_EXECUTE   = 2'd2,
        PH_WRITEBACK = 2'd3
    } phase_e;

    typedef enum logic [3:0] {
        CL_NOP,
        CL_FILE,
        CL_BSKIP,
        CL_FSZ,
        CL_GOTO,
        CL_MOVLW,
        CL_XORLW,
        CL_LIT,
        CL_OTHER
    } instr_class_e;

    // Opcode mask/match pairs on the 12-bit instruction word.
    localparam logic [11:0] OP_FILE_MASK  = 12'hC00;
    localparam logic [11:0] OP_FILE       = 12'h000;
    localparam logic [11:0] OP_FSZ_MASK   = 12'hFC0;
    localparam logic [11:0] OP_DECFSZ     = 12'h2C0;
    localparam logic [11:0] OP_INCFSZ     = 12'h3C0;
    localparam logic [11:0] OP_BSKIP_MASK = 12'hE00;
    localparam logic [11:0] OP_BSKIP      = 12'h600;
    localparam logic [11:0] OP_GOTO_MASK  = 12'hE00;
    localparam logic [11:0] OP_GOTO       = 12'hA00;
    localparam logic [11:0] OP_LIT_MASK   = 12'hF00;
    localparam logic [11:0] OP_MOVLW      = 12'hC00;
    localparam logic [11:0] OP_LIT_A      = 12'hD00;
    localparam logic [11:0] OP_LIT_B      = 12'hE00;
    localparam logic [11:0] OP_XORLW      = 12'hF00;

    localparam logic [1:0] ACC_ALU  = 2'd0;
    localparam logic [1:0] ACC_LIT  = 2'd1;
    localparam logic [1:0] ACC_XOR  = 2'd2;
    localparam logic [1:0] ACC_RSVD = 2'd3;

    function automatic logic op_match(input logic [11:0] ins,
                                      input logic [11:0] mask,
                                      input logic [11:0] match);
        return (ins & mask) == match;
    endfunction

endpackage

// File: rtl/pic_ctrl_decode.sv
// Combinational instruction classifier: IR word to class and write/skip attributes.
module pic_ctrl_decode
    import pic_ctrl_pkg::*;
(
    input  logic [11:0]  ir_i,
    output instr_class_e cls_o,
    output logic         is_skip_o,
    output logic         writes_w_o,
    output logic         writes_f_o
);

    logic file_like;

    // FSZ opcodes sit inside the FILE space, so they must be matched first.
    always_comb begin
        cls_o = CL_OTHER;
        if (ir_i == 12'h000) begin
            cls_o = CL_NOP;
        end else if (op_match(ir_i, OP_FSZ_MASK, OP_DECFSZ) ||
                     op_match(ir_i, OP_FSZ_MASK, OP_INCFSZ)) begin
            cls_o = CL_FSZ;
        end else if (op_match(ir_i, OP_FILE_MASK, OP_FILE)) begin
            cls_o = CL_FILE;
        end else if (op_match(ir_i, OP_BSKIP_MASK, OP_BSKIP)) begin
            cls_o = CL_BSKIP;
        end else if (op_match(ir_i, OP_GOTO_MASK, OP_GOTO)) begin
            cls_o = CL_GOTO;
        end else if (op_match(ir_i, OP_LIT_MASK, OP_MOVLW)) begin
            cls_o = CL_MOVLW;
        end else if (op_match(ir_i, OP_LIT_MASK, OP_XORLW)) begin
            cls_o = CL_XORLW;
        end else if (op_match(ir_i, OP_LIT_MASK, OP_LIT_A) ||
                     op_match(ir_i, OP_LIT_MASK, OP_LIT_B)) begin
            cls_o = CL_LIT;
        end
    end

    assign file_like  = (cls_o == CL_FILE) || (cls_o == CL_FSZ);
    assign is_skip_o  = (cls_o == CL_BSKIP) || (cls_o == CL_FSZ);
    assign writes_f_o = file_like && ir_i[5];
    assign writes_w_o = (file_like && !ir_i[5]) || (cls_o == CL_MOVLW) ||
                        (cls_o == CL_XORLW) || (cls_o == CL_LIT);

endmodule

// File: rtl/pic_ctrl_seq.sv
// Four-phase FETCH/DECODE/EXECUTE/WRITEBACK sequencer with skip annulment and run/halt.
// Define PIC_CTRL_STEP_EN to add the single-step input 'step'.
module pic_ctrl_seq
    import pic_ctrl_pkg::*;
#(
    parameter int PC_W = 9,
    parameter int IW   = 12
) (
    input  logic          CK,
    input  logic          CLR,
    input  logic [IW-1:0] ir,
    input  logic          alu_zero,
    input  logic          run,
`ifdef PIC_CTRL_STEP_EN
    input  logic          step,
`endif
    output logic          ir_we,
    output logic          pc_we,
    output logic          pc_sel,
    output logic          ram_oe,
    output logic          ram_we,
    output logic          w_we,
    output logic [1:0]    acc_src,
    output logic          skip_pending,
    output logic [1:0]    phase,
    output logic          retired
);

    if (IW != 12) begin : g_iw_check
        $error("pic_ctrl_seq: IW must be 12");
    end
    if (PC_W < 9) begin : g_pcw_check
        $error("pic_ctrl_seq: PC_W too narrow for the 9-bit goto target");
    end

    localparam logic [1:0] ST_FETCH     = PH_FETCH;
    localparam logic [1:0] ST_DECODE    = PH_DECODE;
    localparam logic [1:0] ST_EXECUTE   = PH_EXECUTE;
    localparam logic [1:0] ST_WRITEBACK = PH_WRITEBACK;

    instr_class_e dec_cls;
    logic         dec_is_skip;
    logic         dec_writes_w;
    logic         dec_writes_f;

    pic_ctrl_decode u_decode (
        .ir_i       (ir),
        .cls_o      (dec_cls),
        .is_skip_o  (dec_is_skip),
        .writes_w_o (dec_writes_w),
        .writes_f_o (dec_writes_f)
    );

    logic [1:0] phase_q, phase_d;
    logic       skip_q, skip_d;
    logic       annul_q, annul_d;
    logic       go;
    logic       skip_cond;
    logic       reads_f;

`ifdef PIC_CTRL_STEP_EN
    assign go = run | step;
`else
    assign go = run;
`endif

    assign reads_f = (dec_cls == CL_FILE) || (dec_cls == CL_BSKIP) || (dec_cls == CL_FSZ);

    always_comb begin
        skip_cond = 1'b0;
        if (dec_cls == CL_BSKIP) begin
            skip_cond = ir[8] ? ~alu_zero : alu_zero;
        end else if (dec_cls == CL_FSZ) begin
            skip_cond = alu_zero;
        end
    end

    // annul_q marks the instruction in flight as the victim of a skip; skip_q is
    // the visible "next instruction is annulled" flag and survives halts.
    always_comb begin
        phase_d = phase_q;
        skip_d  = skip_q;
        annul_d = annul_q;
        case (phase_q)
            ST_FETCH: begin
                if (go) begin
                    phase_d = ST_DECODE;
                    annul_d = skip_q;
                end
            end
            ST_DECODE:  phase_d = ST_EXECUTE;
            ST_EXECUTE: begin
                phase_d = ST_WRITEBACK;
                if (dec_is_skip && !annul_q) begin
                    skip_d = skip_cond;
                end
            end
            default: begin
                phase_d = ST_FETCH;
                if (annul_q) begin
                    skip_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge CK or posedge CLR) begin
        if (CLR) begin
            phase_q <= ST_FETCH;
            skip_q  <= 1'b0;
            annul_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            skip_q  <= skip_d;
            annul_q <= annul_d;
        end
    end

    always_comb begin
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_sel  = 1'b0;
        ram_oe  = 1'b0;
        ram_we  = 1'b0;
        w_we    = 1'b0;
        acc_src = ACC_ALU;
        retired = 1'b0;
        case (phase_q)
            ST_FETCH:              ir_we  = go & ~CLR;
            ST_DECODE, ST_EXECUTE: ram_oe = reads_f;
            default: begin
                pc_we   = 1'b1;
                pc_sel  = (dec_cls == CL_GOTO) & ~annul_q;
                ram_we  = dec_writes_f & ~annul_q;
                w_we    = dec_writes_w & ~annul_q;
                retired = 1'b1;
                if (dec_cls == CL_MOVLW) begin
                    acc_src = ACC_LIT;
                end else if (dec_cls == CL_XORLW) begin
                    acc_src = ACC_XOR;
                end
            end
        endcase
    end

    assign skip_pending = skip_q;
    assign phase        = phase_q;

endmodule

// File: tb/tb_pic_ctrl_seq.sv
// Self-checking bench for pic_ctrl_seq: instruction-level reference model plus directed pins.
module tb_pic_ctrl_seq;

    typedef struct packed {
        logic       ir_we;
        logic       pc_we;
        logic       pc_sel;
        logic       ram_oe;
        logic       ram_we;
        logic       w_we;
        logic [1:0] acc_src;
        logic       skip_pending;
        logic [1:0] phase;
        logic       retired;
    } obs_t;

    localparam int C_NOP   = 0;
    localparam int C_FILE  = 1;
    localparam int C_BSKIP = 2;
    localparam int C_FSZ   = 3;
    localparam int C_GOTO  = 4;
    localparam int C_MOVLW = 5;
    localparam int C_XORLW = 6;
    localparam int C_LIT   = 7;
    localparam int C_OTHER = 8;

    logic        CK       = 1'b0;
    logic        CLR      = 1'b1;
    logic [11:0] ir       = 12'h000;
    logic        alu_zero = 1'b0;
    logic        run      = 1'b0;
`ifdef PIC_CTRL_STEP_EN
    logic        step     = 1'b0;
`endif
    logic        ir_we, pc_we, pc_sel, ram_oe, ram_we, w_we, skip_pending, retired;
    logic [1:0]  acc_src, phase;

    pic_ctrl_seq #(.PC_W(9), .IW(12)) dut (
        .CK           (CK),
        .CLR          (CLR),
        .ir           (ir),
        .alu_zero     (alu_zero),
        .run          (run),
`ifdef PIC_CTRL_STEP_EN
        .step         (step),
`endif
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .ram_oe       (ram_oe),
        .ram_we       (ram_we),
        .w_we         (w_we),
        .acc_src      (acc_src),
        .skip_pending (skip_pending),
        .phase        (phase),
        .retired      (retired)
    );

    always #5 CK = ~CK;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [11:0] exp_q[$];
    logic        m_skip  = 1'b0;
    logic [8:0]  m_pc    = 9'h000;
    logic [11:0] prev_ir = 12'h000;

    function automatic obs_t mk(input int iw, input int pw, input int ps, input int ro,
                                input int rw, input int ww, input int acc, input int sk,
                                input int ph, input int rt);
        obs_t o;
        o.ir_we        = 1'(iw);
        o.pc_we        = 1'(pw);
        o.pc_sel       = 1'(ps);
        o.ram_oe       = 1'(ro);
        o.ram_we       = 1'(rw);
        o.w_we         = 1'(ww);
        o.acc_src      = 2'(acc);
        o.skip_pending = 1'(sk);
        o.phase        = 2'(ph);
        o.retired      = 1'(rt);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.ir_we        = ir_we;
        o.pc_we        = pc_we;
        o.pc_sel       = pc_sel;
        o.ram_oe       = ram_oe;
        o.ram_we       = ram_we;
        o.w_we         = w_we;
        o.acc_src      = acc_src;
        o.skip_pending = skip_pending;
        o.phase        = phase;
        o.retired      = retired;
        return o;
    endfunction

    function automatic int cls_of(input logic [11:0] i);
        if (i == 12'h000) return C_NOP;
        if (i[11:6] == 6'b001011 || i[11:6] == 6'b001111) return C_FSZ;
        if (i[11:10] == 2'b00) return C_FILE;
        if (i[11:9] == 3'b011) return C_BSKIP;
        if (i[11:9] == 3'b101) return C_GOTO;
        if (i[11:8] == 4'hC) return C_MOVLW;
        if (i[11:8] == 4'hF) return C_XORLW;
        if (i[11:8] == 4'hD || i[11:8] == 4'hE) return C_LIT;
        return C_OTHER;
    endfunction

    function automatic logic [11:0] rand_ins();
        logic [11:0] r;
        r = 12'($urandom_range(0, 4095));
        case ($urandom_range(0, 9))
            0:       return 12'h000;
            1:       return {2'b00, r[9:0]};
            2:       return {3'b011, r[8:0]};
            3:       return {6'b001011, r[5:0]};
            4:       return {6'b001111, r[5:0]};
            5:       return {3'b101, r[8:0]};
            6:       return {4'hC, r[7:0]};
            7:       return {4'hF, r[7:0]};
            8:       return {(r[0] ? 4'hD : 4'hE), r[11:4]};
            default: return r;
        endcase
    endfunction

    task automatic cmp(input string nm, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (ir_we,pc_we,pc_sel,ram_oe,ram_we,w_we,acc_src,skip,phase,retired) t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic pc_cmp(input string nm, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: model pc %h required %h", nm, act, exp);
        end
    endtask

    // One instruction: model predicts four cycles, driver applies inputs, every cycle compared.
    // clr_at >= 0 pulses CLR in that phase after its normal check.
    task automatic do_instr(input logic [11:0] ins, input logic az, input logic [2:0] run_mid,
                            input int clr_at, output obs_t wb_act);
        int   c;
        logic a, rd, ww, wf, gt, set, run_v, az_v;
        logic [1:0]  acc;
        logic [11:0] ir_v;
        obs_t e, act;
        c   = cls_of(ins);
        a   = m_skip;
        rd  = (c == C_FILE) || (c == C_BSKIP) || (c == C_FSZ);
        ww  = (c == C_MOVLW) || (c == C_XORLW) || (c == C_LIT) ||
              (((c == C_FILE) || (c == C_FSZ)) && !ins[5]);
        wf  = ((c == C_FILE) || (c == C_FSZ)) && ins[5];
        gt  = (c == C_GOTO);
        set = !a && (((c == C_BSKIP) && (ins[8] ? !az : az)) || ((c == C_FSZ) && az));
        acc = (c == C_MOVLW) ? 2'd1 : (c == C_XORLW) ? 2'd2 : 2'd0;
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, int'(a), 0, 0));
        exp_q.push_back(mk(0, 0, 0, int'(rd), 0, 0, 0, int'(a), 1, 0));
        exp_q.push_back(mk(0, 0, 0, int'(rd), 0, 0, 0, int'(a), 2, 0));
        exp_q.push_back(mk(0, 1, int'(gt && !a), 0, int'(wf && !a), int'(ww && !a),
                           int'(acc), int'(a || set), 3, 1));
        wb_act = '0;
        for (int p = 0; p < 4; p++) begin
            ir_v  = (p == 0) ? prev_ir : ins;
            az_v  = (p == 2) ? az : 1'($urandom_range(0, 1));
            run_v = 1'b1;
            if (p == 1) run_v = run_mid[0];
            else if (p == 2) run_v = run_mid[1];
            else if (p == 3) run_v = run_mid[2];
            ir       = ir_v;
            alu_zero = az_v;
            run      = run_v;
            #2;
            act = sample();
            e   = exp_q.pop_front();
            cmp($sformatf("model_ph%0d_ir%h", p, ins), act, e);
            if (p == 3) wb_act = act;
            if (p == clr_at) begin
                CLR = 1'b1;
                #1;
                cmp($sformatf("clr_async_ph%0d", p), sample(), '0);
                @(posedge CK);
                #1;
                CLR     = 1'b0;
                m_skip  = 1'b0;
                m_pc    = 9'h000;
                prev_ir = ins;
                exp_q.delete();
                return;
            end
            @(posedge CK);
            #1;
        end
        prev_ir = ins;
        m_skip  = set;
        m_pc    = (gt && !a) ? ins[8:0] : m_pc + 9'd1;
    endtask

    task automatic halt(input int n, output obs_t last);
        obs_t e;
        last = '0;
        for (int k = 0; k < n; k++) begin
            ir       = prev_ir;
            alu_zero = 1'($urandom_range(0, 1));
            run      = 1'b0;
            #2;
            e    = mk(0, 0, 0, 0, 0, 0, 0, int'(m_skip), 0, 0);
            last = sample();
            cmp("halt_model", last, e);
            @(posedge CK);
            #1;
        end
    endtask

    initial begin
        obs_t w;
        repeat (2) @(posedge CK);
        #1;
        ir       = 12'h000;
        run      = 1'b1;
        alu_zero = 1'b0;
        #2;
        cmp("reset_outputs_zero", sample(), '0);
        @(posedge CK);
        #1;
        CLR = 1'b0;

        do_instr(12'hC5A, 1'b0, 3'b111, -1, w);
        cmp("movlw_wb", w, mk(0, 1, 0, 0, 0, 1, 1, 0, 3, 1));
        do_instr(12'hA37, 1'b1, 3'b111, -1, w);
        cmp("goto_wb", w, mk(0, 1, 1, 0, 0, 0, 0, 0, 3, 1));
        pc_cmp("goto_target", m_pc, 9'h037);

        do_instr(12'h645, 1'b1, 3'b111, -1, w);
        cmp("btfsc_taken_wb", w, mk(0, 1, 0, 0, 0, 0, 0, 1, 3, 1));
        do_instr(12'h025, 1'b0, 3'b111, -1, w);
        cmp("annulled_file_wb", w, mk(0, 1, 0, 0, 0, 0, 0, 1, 3, 1));
        pc_cmp("annulled_pc_inc", m_pc, 9'h039);
        do_instr(12'h645, 1'b0, 3'b111, -1, w);
        do_instr(12'h025, 1'b1, 3'b111, -1, w);
        cmp("file_wb", w, mk(0, 1, 0, 0, 1, 0, 0, 0, 3, 1));

        // run dropped in EXECUTE and WRITEBACK
        do_instr(12'hD12, 1'b0, 3'b001, -1, w);
        cmp("run_drop_wb", w, mk(0, 1, 0, 0, 0, 1, 0, 0, 3, 1));
        halt(3, w);
        cmp("halt_hold", w, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        do_instr(12'h745, 1'b0, 3'b111, -1, w);
        halt(2, w);
        cmp("halt_keeps_skip", w, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        do_instr(12'h3E5, 1'b1, 3'b111, -1, w);
        cmp("annulled_incfsz_wb", w, mk(0, 1, 0, 0, 0, 0, 0, 1, 3, 1));
        do_instr(12'h000, 1'b1, 3'b111, -1, w);
        cmp("nop_after_b2b_skip", w, mk(0, 1, 0, 0, 0, 0, 0, 0, 3, 1));

        for (int k = 0; k < 300; k++) begin
            do_instr(rand_ins(), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), -1, w);
            if ($urandom_range(0, 3) == 0) halt($urandom_range(1, 3), w);
        end

        if (m_skip) do_instr(12'h000, 1'b0, 3'b111, -1, w);
        do_instr(12'hF0F, 1'b0, 3'b111, 3, w);
        do_instr(12'h645, 1'b1, 3'b111, -1, w);
        do_instr(12'h025, 1'b0, 3'b111, 1, w);
        do_instr(12'hC5A, 1'b0, 3'b111, -1, w);
        cmp("restart_movlw_wb", w, mk(0, 1, 0, 0, 0, 1, 1, 0, 3, 1));
        pc_cmp("restart_pc", m_pc, 9'h001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
